mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the instruction-fetch requester and the load/store requester.
- The load/store side is driven by the decoder's mem_rd_en/mem_wr_en.
- Supports one outstanding memory transaction at a time.
- Data requests have priority; a bounded-burst counter guarantees fetch progress.
- Sits between the core pipeline and the memory/bus interface.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- MAX_DATA_BURST, 4, maximum consecutive data grants while a fetch waits; legal range 1..15

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  fetch request pending
- if_addr  in  ADDR_W  fetch address
- if_req_ready  out  1  fetch request accepted this cycle
- if_rsp_valid  out  1  fetch response, one-cycle pulse
- if_rsp_data  out  DATA_W  fetched instruction
- d_req_valid  in  1  load/store request pending
- d_wr_en  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  store byte strobes
- d_req_ready  out  1  data request accepted this cycle
- d_rsp_valid  out  1  load data / store ack, one-cycle pulse
- d_rsp_data  out  DATA_W  load data; memory value passed through on store ack
- mem_req_valid  out  1  request to memory
- mem_wr_en  out  1  write request
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data
- mem_wstrb  out  DATA_W/8  write strobes
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  memory response or write ack
- mem_rsp_data  in  DATA_W  response data
- busy  out  1  state != IDLE
- proto_err  out  1  sticky: mem_rsp_valid seen outside WAIT_RSP

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, owner FETCH, burst_cnt 0, request registers 0, proto_err 0.
- FSM states are IDLE, ISSUE, WAIT_RSP.
- IDLE, grant decision (combinational, same cycle):
  - Data wins if d_req_valid && (!if_req_valid || burst_cnt < MAX_DATA_BURST).
  - Otherwise fetch wins if if_req_valid.
  - The winner's *_req_ready is asserted for that cycle only. Its addr/wdata/wstrb/wr_en and owner are registered.
  - If either requester wins, go to ISSUE. With no request, stay in IDLE.
  - Fetch requests always use wr_en=0 and wstrb=0.
- burst_cnt update at a grant:
  - Data grant while if_req_valid: increment, saturating at MAX_DATA_BURST.
  - Data grant while !if_req_valid: clear to 0.
  - Fetch grant: clear to 0.
- ISSUE:
  - mem_req_valid=1 and mem_* driven from the registers.
  - mem_* must stay stable until mem_req_ready. On mem_req_ready, go to WAIT_RSP.
- WAIT_RSP:
  - mem_req_valid=0. Wait for mem_rsp_valid for any number of cycles; there is no timeout.
  - On mem_rsp_valid, register the data and go to IDLE.
  - In the next cycle, the owner's *_rsp_valid pulses for one cycle with the registered data. The other requester's rsp_valid stays 0.
- Latency:
  - Grant at cycle 0; mem_req_valid at cycle 1.
  - With mem_req_ready at 1 and mem_rsp_valid at 2, rsp_valid is at 3.
  - Next grant is possible at cycle 3, the same cycle as rsp_valid.
- Requesters may deassert *_req_valid before ready without error; nothing is latched in that case.
- mem_rsp_valid in IDLE or ISSUE is ignored and sets proto_err. Only reset clears proto_err.
- Reset mid-transaction: abandon the transaction and return to IDLE. A late memory response afterwards sets proto_err and produces no rsp_valid.
- *_rsp_data holds its last value between pulses.

Decomposition:
- Shared package mem_arb_pkg:
  - mem_owner_e enum {OWNER_FETCH, OWNER_DATA}
  - mem_arb_state_e enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT_RSP}
  - mem_req_t struct {wr_en, addr, wdata, wstrb}
- Sub-module mem_arb_select: combinational winner selection plus the burst_cnt register and its update.

Test Plan:
- Fetch only: if_addr=0x100, mem_req_ready at cycle 1, mem_rsp_valid with 0x00500093 at cycle 2 -> if_req_ready at cycle 0, mem_addr=0x100/mem_wr_en=0 at cycle 1, if_rsp_valid with 0x00500093 at cycle 3, d_rsp_valid never asserted.
- Simultaneous requests, both valid continuously, MAX_DATA_BURST=4, single-cycle memory -> grant order D,D,D,D,F,D,D,D,D,F…
- Store: d_wr_en=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=4'b0011, mem_req_ready held low 5 cycles -> mem_* stable all 5 cycles, d_rsp_valid 1 cycle after mem_rsp_valid.
- Backpressure: mem_rsp_valid delayed 20 cycles -> busy=1 throughout, no second grant, no req_ready pulses.
- Reset during WAIT_RSP, then spurious mem_rsp_valid -> all outputs 0 during reset, no rsp_valid after it, proto_err=1.
- Data only (if_req_valid=0) for 10 requests -> burst_cnt stays 0, all 10 granted, with a fetch arriving after them granted within 1 transaction.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the fetch/data memory port arbiter
package mem_arb_pkg;

    localparam int MEM_ADDR_W  = 32;
    localparam int MEM_DATA_W  = 32;
    localparam int MEM_STRB_W  = MEM_DATA_W / 8;
    localparam int BURST_CNT_W = 4;

    typedef enum logic {
        OWNER_FETCH,
        OWNER_DATA
    } mem_owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_RSP
    } mem_arb_state_e;

    typedef struct packed {
        logic                  wr_en;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_STRB_W-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - single-ported memory request/response bus
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                mem_req_valid;
    logic                mem_wr_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic                mem_req_ready;
    logic                mem_rsp_valid;
    logic [DATA_W-1:0]   mem_rsp_data;

    modport master (
        output mem_req_valid, mem_wr_en, mem_addr, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport slave (
        input  mem_req_valid, mem_wr_en, mem_addr, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/mem_arb_select.sv
// rtl/mem_arb_select.sv - winner selection with bounded data burst
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   grant_en,
    input  logic                   if_req_valid,
    input  logic                   d_req_valid,
    output logic                   grant_fetch,
    output logic                   grant_data,
    output logic [BURST_CNT_W-1:0] burst_cnt
);
    localparam logic [BURST_CNT_W-1:0] MAX_CNT = BURST_CNT_W'(MAX_DATA_BURST);

    // Data wins until it has taken MAX_DATA_BURST grants in a row over a waiting fetch.
    always_comb begin
        grant_data  = grant_en && d_req_valid && (!if_req_valid || (burst_cnt < MAX_CNT));
        grant_fetch = grant_en && if_req_valid && !grant_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (grant_data && if_req_valid) begin
            if (burst_cnt < MAX_CNT) begin
                burst_cnt <= burst_cnt + BURST_CNT_W'(1);
            end
        end else if (grant_data || grant_fetch) begin
            burst_cnt <= '0;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = MEM_ADDR_W,
    parameter int DATA_W         = MEM_DATA_W,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                d_req_valid,
    input  logic                d_wr_en,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_req_ready,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_data,
    mem_port_arbiter_if.master  mem,
    output logic                busy,
    output logic                proto_err
);
    mem_arb_state_e         state_q, state_d;
    mem_owner_e             owner_q;
    mem_req_t               req_q;
    logic                   grant_fetch, grant_data;
    logic [BURST_CNT_W-1:0] burst_cnt;

    mem_arb_select #(.MAX_DATA_BURST(MAX_DATA_BURST)) u_select (
        .clk          (clk),
        .rst_n        (rst_n),
        .grant_en     (state_q == ARB_IDLE),
        .if_req_valid (if_req_valid),
        .d_req_valid  (d_req_valid),
        .grant_fetch  (grant_fetch),
        .grant_data   (grant_data),
        .burst_cnt    (burst_cnt)
    );

    assign if_req_ready  = grant_fetch;
    assign d_req_ready   = grant_data;
    assign busy          = (state_q != ARB_IDLE);
    assign mem.mem_wr_en = req_q.wr_en;
    assign mem.mem_addr  = ADDR_W'(req_q.addr);
    assign mem.mem_wdata = DATA_W'(req_q.wdata);
    assign mem.mem_wstrb = (DATA_W/8)'(req_q.wstrb);

    always_comb begin
        state_d           = state_q;
        mem.mem_req_valid = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_data || grant_fetch) state_d = ARB_ISSUE;
            end
            ARB_ISSUE: begin
                mem.mem_req_valid = 1'b1;
                if (mem.mem_req_ready) state_d = ARB_WAIT_RSP;
            end
            ARB_WAIT_RSP: begin
                if (mem.mem_rsp_valid) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWNER_FETCH;
            req_q        <= '0;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            d_rsp_valid  <= 1'b0;
            d_rsp_data   <= '0;
            proto_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            if_rsp_valid <= 1'b0;
            d_rsp_valid  <= 1'b0;
            if (grant_data) begin
                owner_q <= OWNER_DATA;
                req_q   <= '{wr_en: d_wr_en,
                             addr:  MEM_ADDR_W'(d_addr),
                             wdata: MEM_DATA_W'(d_wdata),
                             wstrb: MEM_STRB_W'(d_wstrb)};
            end else if (grant_fetch) begin
                owner_q <= OWNER_FETCH;
                req_q   <= '{wr_en: 1'b0, addr: MEM_ADDR_W'(if_addr), wdata: '0, wstrb: '0};
            end
            if (state_q == ARB_WAIT_RSP && mem.mem_rsp_valid) begin
                if (owner_q == OWNER_DATA) begin
                    d_rsp_valid <= 1'b1;
                    d_rsp_data  <= mem.mem_rsp_data;
                end else begin
                    if_rsp_valid <= 1'b1;
                    if_rsp_data  <= mem.mem_rsp_data;
                end
            end
            // A response with no transaction in flight (e.g. after a reset) is a protocol fault.
            if (mem.mem_rsp_valid && state_q != ARB_WAIT_RSP) proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req_valid;
    logic [AW-1:0] if_addr;
    logic          if_req_ready;
    logic          if_rsp_valid;
    logic [DW-1:0] if_rsp_data;
    logic          d_req_valid;
    logic          d_wr_en;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_wstrb;
    logic          d_req_ready;
    logic          d_rsp_valid;
    logic [DW-1:0] d_rsp_data;
    logic          busy;
    logic          proto_err;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_BURST(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req_valid (if_req_valid),
        .if_addr      (if_addr),
        .if_req_ready (if_req_ready),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .d_req_valid  (d_req_valid),
        .d_wr_en      (d_wr_en),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_wstrb      (d_wstrb),
        .d_req_ready  (d_req_ready),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .mem          (mem_bus),
        .busy         (busy),
        .proto_err    (proto_err)
    );

    typedef struct {
        bit          is_data;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    bit   grant_log[$];
    exp_t mon_e;
    exp_t mon_push;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Scoreboard: expected response pushed at each grant, popped at each rsp pulse.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (if_req_ready === 1'b1) begin
                mon_push.is_data = 1'b0;
                mon_push.data    = mem_model(if_addr);
                sb.push_back(mon_push);
                grant_log.push_back(1'b0);
            end
            if (d_req_ready === 1'b1) begin
                mon_push.is_data = 1'b1;
                mon_push.data    = mem_model(d_addr);
                sb.push_back(mon_push);
                grant_log.push_back(1'b1);
            end
            if (if_rsp_valid === 1'b1 || d_rsp_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_rsp: if_rsp_valid=%b d_rsp_valid=%b required no response",
                             if_rsp_valid, d_rsp_valid);
                end else begin
                    mon_e = sb.pop_front();
                    if ((if_rsp_valid && d_rsp_valid) || d_rsp_valid !== mon_e.is_data ||
                        (mon_e.is_data ? d_rsp_data : if_rsp_data) !== mon_e.data) begin
                        errors++;
                        $display("FAIL sb_rsp: if_v=%b d_v=%b if_data=%h d_data=%h required owner_data=%b data=%h",
                                 if_rsp_valid, d_rsp_valid, if_rsp_data, d_rsp_data,
                                 mon_e.is_data, mon_e.data);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic mem_serve(input int rdly, input int sdly);
        int          n = 0;
        logic        w;
        logic [31:0] a, wd;
        logic [3:0]  ws;
        @(negedge clk);
        while (mem_bus.mem_req_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mem_bus.mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL mem_req_timeout: mem_req_valid=%b required 1", mem_bus.mem_req_valid);
            return;
        end
        w  = mem_bus.mem_wr_en;
        a  = mem_bus.mem_addr;
        wd = mem_bus.mem_wdata;
        ws = mem_bus.mem_wstrb;
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            checks++;
            if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_wr_en !== w || mem_bus.mem_addr !== a ||
                mem_bus.mem_wdata !== wd || mem_bus.mem_wstrb !== ws) begin
                errors++;
                $display("FAIL mem_stable: v=%b we=%b addr=%h wdata=%h wstrb=%h required 1 %b %h %h %h",
                         mem_bus.mem_req_valid, mem_bus.mem_wr_en, mem_bus.mem_addr,
                         mem_bus.mem_wdata, mem_bus.mem_wstrb, w, a, wd, ws);
            end
        end
        mem_bus.mem_req_ready = 1'b1;
        @(posedge clk);
        #1 mem_bus.mem_req_ready = 1'b0;
        for (int i = 0; i < sdly; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || mem_bus.mem_req_valid !== 1'b0 || if_req_ready !== 1'b0 ||
                d_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL wait_rsp_idle: busy=%b mem_req_valid=%b if_ready=%b d_ready=%b required 1 0 0 0",
                         busy, mem_bus.mem_req_valid, if_req_ready, d_req_ready);
            end
        end
        @(negedge clk);
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_data  = mem_model(a);
        @(posedge clk);
        #1;
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rsp_data  = '0;
    endtask

    task automatic check_all_zero(input string name);
        logic [255:0] outs;
        outs = 256'({if_req_ready, if_rsp_valid, if_rsp_data, d_req_ready, d_rsp_valid, d_rsp_data,
                     mem_bus.mem_req_valid, mem_bus.mem_wr_en, mem_bus.mem_addr, mem_bus.mem_wdata,
                     mem_bus.mem_wstrb, busy, proto_err});
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL %s: outputs=%h required 0", name, outs);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || proto_err !== 1'b0 || dut.u_select.burst_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_release: busy=%b proto_err=%b burst_cnt=%0d required 0 0 0",
                     busy, proto_err, dut.u_select.burst_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_fetch_only();
        if_req_valid = 1'b1;
        if_addr      = 32'h0000_0100;
        @(negedge clk);
        checks++;
        if (if_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL fetch_grant: if_ready=%b d_ready=%b required 1 0", if_req_ready, d_req_ready);
        end
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        if_addr      = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_addr !== 32'h100 ||
            mem_bus.mem_wr_en !== 1'b0 || mem_bus.mem_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL fetch_issue: v=%b addr=%h we=%b wstrb=%h required 1 00000100 0 0",
                     mem_bus.mem_req_valid, mem_bus.mem_addr, mem_bus.mem_wr_en, mem_bus.mem_wstrb);
        end
        mem_bus.mem_req_ready = 1'b1;
        @(posedge clk);
        #1 mem_bus.mem_req_ready = 1'b0;
        @(negedge clk);
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_data  = 32'h0050_0093;
        @(posedge clk);
        #1;
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rsp_data  = '0;
        @(negedge clk);
        checks++;
        if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h0050_0093 || d_rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fetch_rsp: if_v=%b data=%h d_v=%b busy=%b required 1 00500093 0 0",
                     if_rsp_valid, if_rsp_data, d_rsp_valid, busy);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (if_rsp_valid !== 1'b0 || if_rsp_data !== 32'h0050_0093 || d_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_rsp_hold: if_v=%b data=%h d_v=%b required 0 00500093 0",
                     if_rsp_valid, if_rsp_data, d_rsp_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_priority_burst();
        bit exp_order [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        grant_log.delete();
        if_addr      = 32'h0000_0400;
        d_addr       = 32'h0000_3000;
        d_wr_en      = 1'b0;
        if_req_valid = 1'b1;
        d_req_valid  = 1'b1;
        fork
            begin
                int n = 0;
                while (grant_log.size() < 10 && n < 200) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                @(posedge clk);
                #1;
                if_req_valid = 1'b0;
                d_req_valid  = 1'b0;
            end
            begin
                for (int i = 0; i < 10; i++) mem_serve(0, 0);
            end
        join
        checks++;
        if (grant_log.size() != 10) begin
            errors++;
            $display("FAIL burst_count: grants=%0d required 10", grant_log.size());
        end
        for (int i = 0; i < 10 && i < grant_log.size(); i++) begin
            checks++;
            if (grant_log[i] !== exp_order[i]) begin
                errors++;
                $display("FAIL burst_order[%0d]: data_grant=%b required %b", i, grant_log[i], exp_order[i]);
            end
        end
    endtask

    task automatic test_store();
        d_wr_en     = 1'b1;
        d_addr      = 32'h0000_2000;
        d_wdata     = 32'hDEAD_BEEF;
        d_wstrb     = 4'b0011;
        d_req_valid = 1'b1;
        fork
            begin
                @(negedge clk);
                checks++;
                if (d_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL store_grant: d_ready=%b if_ready=%b required 1 0", d_req_ready, if_req_ready);
                end
                @(posedge clk);
                #1;
                d_req_valid = 1'b0;
                d_addr      = '0;
                d_wdata     = '0;
                d_wstrb     = '0;
                @(negedge clk);
                checks++;
                if (mem_bus.mem_wr_en !== 1'b1 || mem_bus.mem_addr !== 32'h2000 ||
                    mem_bus.mem_wdata !== 32'hDEAD_BEEF || mem_bus.mem_wstrb !== 4'b0011) begin
                    errors++;
                    $display("FAIL store_fields: we=%b addr=%h wdata=%h wstrb=%b required 1 00002000 deadbeef 0011",
                             mem_bus.mem_wr_en, mem_bus.mem_addr, mem_bus.mem_wdata, mem_bus.mem_wstrb);
                end
            end
            mem_serve(5, 0);
        join
        @(negedge clk);
        checks++;
        if (d_rsp_valid !== 1'b1 || d_rsp_data !== mem_model(32'h2000) || if_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL store_ack: d_v=%b data=%h if_v=%b required 1 %h 0",
                     d_rsp_valid, d_rsp_data, if_rsp_valid, mem_model(32'h2000));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        if_req_valid = 1'b1;
        if_addr      = 32'h0000_0500;
        @(negedge clk);
        checks++;
        if (if_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_grant: if_ready=%b required 1", if_req_ready);
        end
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        d_req_valid  = 1'b1;
        d_wr_en      = 1'b0;
        d_addr       = 32'h0000_3100;
        mem_serve(0, 20);
        @(negedge clk);
        checks++;
        if (d_req_ready !== 1'b1 || if_rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_regrant: d_ready=%b if_rsp_valid=%b required 1 1", d_req_ready, if_rsp_valid);
        end
        @(posedge clk);
        #1 d_req_valid = 1'b0;
        mem_serve(0, 0);
        @(negedge clk);
        checks++;
        if (d_rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_data_rsp: d_rsp_valid=%b required 1", d_rsp_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_data_only();
        int n;
        if_req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            d_req_valid = 1'b1;
            d_wr_en     = i[0];
            d_addr      = 32'h0000_4000 + 32'(i * 4);
            d_wdata     = 32'(i) * 32'h1111_1111;
            d_wstrb     = 4'hF;
            @(negedge clk);
            checks++;
            if (d_req_ready !== 1'b1) begin
                errors++;
                $display("FAIL data_only_grant[%0d]: d_ready=%b required 1", i, d_req_ready);
            end
            @(posedge clk);
            #1 d_req_valid = 1'b0;
            checks++;
            if (dut.u_select.burst_cnt !== 4'd0) begin
                errors++;
                $display("FAIL data_only_burst[%0d]: burst_cnt=%0d required 0", i, dut.u_select.burst_cnt);
            end
            mem_serve(0, 0);
        end
        if_req_valid = 1'b1;
        if_addr      = 32'h0000_0700;
        n = 0;
        @(negedge clk);
        while (if_req_ready !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (if_req_ready !== 1'b1 || n != 0) begin
            errors++;
            $display("FAIL data_only_fetch: if_ready=%b wait=%0d required 1 0", if_req_ready, n);
        end
        @(posedge clk);
        #1 if_req_valid = 1'b0;
        mem_serve(0, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        if_req_valid = 1'b1;
        if_addr      = 32'h0000_0600;
        @(negedge clk);
        @(posedge clk);
        #1 if_req_valid = 1'b0;
        @(negedge clk);
        mem_bus.mem_req_ready = 1'b1;
        @(posedge clk);
        #1 mem_bus.mem_req_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || mem_bus.mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_wait: busy=%b mem_req_valid=%b required 1 0", busy, mem_bus.mem_req_valid);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("rmid_outputs");
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL rmid_proto_clear: proto_err=%b required 0", proto_err);
        end
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_data  = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rsp_data  = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (if_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0 || proto_err !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rmid_late_rsp[%0d]: if_v=%b d_v=%b proto_err=%b busy=%b required 0 0 1 0",
                         i, if_rsp_valid, d_rsp_valid, proto_err, busy);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n                 = 1'b0;
        if_req_valid          = 1'b0;
        if_addr               = '0;
        d_req_valid           = 1'b0;
        d_wr_en               = 1'b0;
        d_addr                = '0;
        d_wdata               = '0;
        d_wstrb               = '0;
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rsp_data  = '0;
        #1;
        test_reset();
        test_fetch_only();
        test_priority_burst();
        test_store();
        test_backpressure();
        test_data_only();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: pending=%0d required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
